pipeline_front_regs: RTL and testbench
======================================

PIPELINE_FRONT_REGS -- requirements
Module: pipeline_front_regs

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 stall  input  1  load-use stall request from HazardUnit.
REQ-007 flush  input  1  branch/jump taken in EX; squashes IF/ID and ID/EX.
REQ-008 branch_target  input  32  next PC when flush=1.
REQ-009 if_instr  input  32  instruction word fetched at pc.
REQ-010 id_memRead, id_regWrite  input  1 each  decoded controls for the current IF/ID instruction.
REQ-011 pc  output  32  current fetch address.
REQ-012 if_id_instr, if_id_pc  output  32 each  IF/ID register contents.
REQ-013 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-014 if_id_rs1_idx, if_id_rs2_idx  output  5 each  if_id_instr[19:15] and [24:20], to HazardUnit.
REQ-015 id_ex_memRead, id_ex_regWrite, id_ex_valid  output  1 each  ID/EX controls.
REQ-016 id_ex_rd_idx, id_ex_rs1_idx, id_ex_rs2_idx  output  5 each  ID/EX register indices, to HazardUnit and ForwardUnit.
REQ-017 ex_mem_regWrite, mem_wb_regWrite  output  1 each  and ex_mem_rd_idx, mem_wb_rd_idx  output  5 each  forwarding sources for ForwardUnit.
REQ-018 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-019 PC update per cycle, priority order: flush -> branch_target; else stall -> hold; else pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-020 IF/ID update, same priority: flush -> instr=NOP (32'h0000_0013), pc=0, valid=0; stall -> hold all fields; else load if_instr, pc, valid=1.
REQ-021 ID/EX update: flush or stall -> insert bubble (valid=0, memRead=0, regWrite=0, rd/rs1/rs2=0); else load id_memRead, id_regWrite, if_id_instr[11:7], rs1, rs2 indices and valid=if_id_valid.
REQ-022 Loaded regWrite SHALL be forced to 0 when the rd index is 0 or the source valid is 0; memRead likewise gated by valid.
REQ-023 EX/MEM and MEM/WB advance every cycle regardless of stall/flush: EX/MEM <= ID/EX (regWrite, rd); MEM/WB <= EX/MEM.
REQ-024 Latency: an instruction fetched in cycle N appears in IF/ID at N+1, ID/EX at N+2, EX/MEM at N+3, MEM/WB at N+4, absent stalls.
REQ-025 stall=1 and flush=1 in the same cycle: flush wins for PC and IF/ID; ID/EX bubbles; both counters increment.
REQ-026 stall_cnt increments by 1 in each cycle stall=1; flush_cnt in each cycle flush=1; both saturate at all-ones, no wrap.
REQ-027 Consecutive stall cycles SHALL hold PC and IF/ID indefinitely and inject one bubble per cycle into ID/EX.

Reset
REQ-028 With rst=1 at a clock edge: pc=RESET_PC; IF/ID instr=NOP, pc=0, valid=0; all ID/EX, EX/MEM, MEM/WB fields 0; counters 0.
REQ-029 rst overrides stall and flush; reset mid-operation discards all in-flight instructions in one cycle.
REQ-030 First fetch after reset deassertion is at RESET_PC; if_id_valid rises one cycle later.

Structure
REQ-031 Shared package pipe_pkg SHALL hold NOP_INSTR, XLEN=32, REG_IDX_W=5 and an id_ex_t struct (valid, memRead, regWrite, rd, rs1, rs2).
REQ-032 One sub-module pipe_reg (parameterised width; load-enable, synchronous clear-to-value, hold) SHALL implement the IF/ID and ID/EX registers.

Verification
REQ-033 Reset, then 4 free-running cycles, no stall/flush -> pc 0,4,8,12,16; if_id_valid=1 from cycle 2; stall_cnt=flush_cnt=0.
REQ-034 Load x3 (rd=3, memRead=1) followed by add using rs1=3, stall=1 for 1 cycle -> pc and if_id_instr held; id_ex_valid=0, id_ex_rd_idx=0 that cycle; stall_cnt=1.
REQ-035 flush=1, branch_target=32'h0000_0100 -> next pc=0x100; if_id_instr=32'h0000_0013, if_id_valid=0; ID/EX bubble; EX/MEM still receives prior ID/EX contents.
REQ-036 stall=1 and flush=1 together, target 0x200 -> pc=0x200, IF/ID squashed, stall_cnt and flush_cnt each +1.
REQ-037 Instruction with rd=0, id_regWrite=1 -> id_ex_regWrite=0, ex_mem_regWrite=0 three cycles later; rd=7 regWrite=1 -> ex_mem_rd_idx=7, ex_mem_regWrite=1, then mem_wb_rd_idx=7.
REQ-038 Hold stall=1 for 2^CNT_W+2 cycles (CNT_W=4) -> stall_cnt=4'hF, no wrap; rst asserted mid-stall -> all state per REQ-028.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the front-end pipeline registers.
package pipe_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic                 valid;
        logic                 memRead;
        logic                 regWrite;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } if_id_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;
    localparam if_id_t IF_ID_EMPTY  = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: clear-to-value has priority over load; otherwise holds.
module pipe_reg #(
    parameter int unsigned     WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = CLR_VAL;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= CLR_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipeline_front_regs.sv
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers with stall/flush handling and event counters.
module pipeline_front_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      if_instr,
    input  logic             id_memRead,
    input  logic             id_regWrite,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic             if_id_valid,
    output logic [4:0]       if_id_rs1_idx,
    output logic [4:0]       if_id_rs2_idx,
    output logic             id_ex_memRead,
    output logic             id_ex_regWrite,
    output logic             id_ex_valid,
    output logic [4:0]       id_ex_rd_idx,
    output logic [4:0]       id_ex_rs1_idx,
    output logic [4:0]       id_ex_rs2_idx,
    output logic             ex_mem_regWrite,
    output logic             mem_wb_regWrite,
    output logic [4:0]       ex_mem_rd_idx,
    output logic [4:0]       mem_wb_rd_idx,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [XLEN-1:0]      pc_d, pc_q;
    if_id_t               if_id_d, if_id_q;
    id_ex_t               id_ex_d, id_ex_q;
    logic                 ex_mem_regwrite_d, ex_mem_regwrite_q;
    logic [REG_IDX_W-1:0] ex_mem_rd_d, ex_mem_rd_q;
    logic                 mem_wb_regwrite_d, mem_wb_regwrite_q;
    logic [REG_IDX_W-1:0] mem_wb_rd_d, mem_wb_rd_q;
    logic [CNT_W-1:0]     stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0]     flush_cnt_d, flush_cnt_q;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (flush) begin
            pc_d = branch_target;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        if_id_d       = '0;
        if_id_d.instr = if_instr;
        if_id_d.pc    = pc_q;
        if_id_d.valid = 1'b1;
    end

    // Controls loaded from an invalid slot or targeting x0 must never cause a write.
    always_comb begin
        id_ex_d          = '0;
        id_ex_d.valid    = if_id_q.valid;
        id_ex_d.rd       = if_id_q.instr[11:7];
        id_ex_d.rs1      = if_id_q.instr[19:15];
        id_ex_d.rs2      = if_id_q.instr[24:20];
        id_ex_d.memRead  = id_memRead & if_id_q.valid;
        id_ex_d.regWrite = id_regWrite & if_id_q.valid & (if_id_q.instr[11:7] != '0);
    end

    always_comb begin
        ex_mem_regwrite_d = id_ex_q.regWrite;
        ex_mem_rd_d       = id_ex_q.rd;
        mem_wb_regwrite_d = ex_mem_regwrite_q;
        mem_wb_rd_d       = ex_mem_rd_q;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q              <= RESET_PC;
            ex_mem_regwrite_q <= 1'b0;
            ex_mem_rd_q       <= '0;
            mem_wb_regwrite_q <= 1'b0;
            mem_wb_rd_q       <= '0;
            stall_cnt_q       <= '0;
            flush_cnt_q       <= '0;
        end else begin
            pc_q              <= pc_d;
            ex_mem_regwrite_q <= ex_mem_regwrite_d;
            ex_mem_rd_q       <= ex_mem_rd_d;
            mem_wb_regwrite_q <= mem_wb_regwrite_d;
            mem_wb_rd_q       <= mem_wb_rd_d;
            stall_cnt_q       <= stall_cnt_d;
            flush_cnt_q       <= flush_cnt_d;
        end
    end

    pipe_reg #(
        .WIDTH   ($bits(if_id_t)),
        .CLR_VAL (IF_ID_EMPTY)
    ) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (~stall),
        .clear (flush),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    // Stall and flush both turn the ID/EX slot into a bubble.
    pipe_reg #(
        .WIDTH   ($bits(id_ex_t)),
        .CLR_VAL (ID_EX_BUBBLE)
    ) u_id_ex (
        .clk   (clk),
        .rst   (rst),
        .load  (1'b1),
        .clear (stall | flush),
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    assign pc              = pc_q;
    assign if_id_instr     = if_id_q.instr;
    assign if_id_pc        = if_id_q.pc;
    assign if_id_valid     = if_id_q.valid;
    assign if_id_rs1_idx   = if_id_q.instr[19:15];
    assign if_id_rs2_idx   = if_id_q.instr[24:20];
    assign id_ex_memRead   = id_ex_q.memRead;
    assign id_ex_regWrite  = id_ex_q.regWrite;
    assign id_ex_valid     = id_ex_q.valid;
    assign id_ex_rd_idx    = id_ex_q.rd;
    assign id_ex_rs1_idx   = id_ex_q.rs1;
    assign id_ex_rs2_idx   = id_ex_q.rs2;
    assign ex_mem_regWrite = ex_mem_regwrite_q;
    assign ex_mem_rd_idx   = ex_mem_rd_q;
    assign mem_wb_regWrite = mem_wb_regwrite_q;
    assign mem_wb_rd_idx   = mem_wb_rd_q;
    assign stall_cnt       = stall_cnt_q;
    assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_front_regs.sv
// Scoreboard bench for pipeline_front_regs: expected state queued at drive time, compared after the edge.
module tb_pipeline_front_regs;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst, stall, flush, id_memRead, id_regWrite;
    logic [31:0]   branch_target, if_instr;
    logic [31:0]   pc, if_id_instr, if_id_pc;
    logic          if_id_valid, id_ex_memRead, id_ex_regWrite, id_ex_valid;
    logic [4:0]    if_id_rs1_idx, if_id_rs2_idx, id_ex_rd_idx, id_ex_rs1_idx, id_ex_rs2_idx;
    logic          ex_mem_regWrite, mem_wb_regWrite;
    logic [4:0]    ex_mem_rd_idx, mem_wb_rd_idx;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_front_regs #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .branch_target   (branch_target),
        .if_instr        (if_instr),
        .id_memRead      (id_memRead),
        .id_regWrite     (id_regWrite),
        .pc              (pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .if_id_rs1_idx   (if_id_rs1_idx),
        .if_id_rs2_idx   (if_id_rs2_idx),
        .id_ex_memRead   (id_ex_memRead),
        .id_ex_regWrite  (id_ex_regWrite),
        .id_ex_valid     (id_ex_valid),
        .id_ex_rd_idx    (id_ex_rd_idx),
        .id_ex_rs1_idx   (id_ex_rs1_idx),
        .id_ex_rs2_idx   (id_ex_rs2_idx),
        .ex_mem_regWrite (ex_mem_regWrite),
        .mem_wb_regWrite (mem_wb_regWrite),
        .ex_mem_rd_idx   (ex_mem_rd_idx),
        .mem_wb_rd_idx   (mem_wb_rd_idx),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    typedef struct {
        logic [31:0]   pc, ifid_instr, ifid_pc;
        logic          ifid_v, idex_v, idex_mr, idex_rw, exm_rw, mwb_rw;
        logic [4:0]    idex_rd, idex_rs1, idex_rs2, exm_rd, mwb_rd;
        logic [CW-1:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    // Advance the reference model by one clock using the inputs about to be applied.
    task automatic model_step(input logic r, input logic s, input logic f, input logic [31:0] tgt,
                              input logic [31:0] ins, input logic mr, input logic rw);
        logic [31:0] old_instr;
        if (r) begin
            m.pc = 32'h0; m.ifid_instr = 32'h0000_0013; m.ifid_pc = 0; m.ifid_v = 0;
            m.idex_v = 0; m.idex_mr = 0; m.idex_rw = 0; m.idex_rd = 0; m.idex_rs1 = 0; m.idex_rs2 = 0;
            m.exm_rw = 0; m.exm_rd = 0; m.mwb_rw = 0; m.mwb_rd = 0; m.sc = 0; m.fc = 0;
            return;
        end
        m.mwb_rw = m.exm_rw;  m.mwb_rd = m.exm_rd;
        m.exm_rw = m.idex_rw; m.exm_rd = m.idex_rd;
        old_instr = m.ifid_instr;
        if (s || f) begin
            m.idex_v = 0; m.idex_mr = 0; m.idex_rw = 0; m.idex_rd = 0; m.idex_rs1 = 0; m.idex_rs2 = 0;
        end else begin
            m.idex_v   = m.ifid_v;
            m.idex_rd  = old_instr[11:7];
            m.idex_rs1 = old_instr[19:15];
            m.idex_rs2 = old_instr[24:20];
            m.idex_mr  = mr && m.ifid_v;
            m.idex_rw  = rw && m.ifid_v && (old_instr[11:7] != 5'd0);
        end
        if (f) begin
            m.ifid_instr = 32'h0000_0013; m.ifid_pc = 0; m.ifid_v = 0;
        end else if (!s) begin
            m.ifid_instr = ins; m.ifid_pc = m.pc; m.ifid_v = 1;
        end
        if (f) m.pc = tgt;
        else if (!s) m.pc = m.pc + 32'd4;
        if (s && m.sc != {CW{1'b1}}) m.sc = m.sc + 1'b1;
        if (f && m.fc != {CW{1'b1}}) m.fc = m.fc + 1'b1;
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("pc", pc, e.pc);
        check_eq("if_id_instr", if_id_instr, e.ifid_instr);
        check_eq("if_id_pc", if_id_pc, e.ifid_pc);
        check_eq("if_id_valid", 32'(if_id_valid), 32'(e.ifid_v));
        check_eq("if_id_rs1", 32'(if_id_rs1_idx), 32'(e.ifid_instr[19:15]));
        check_eq("if_id_rs2", 32'(if_id_rs2_idx), 32'(e.ifid_instr[24:20]));
        check_eq("id_ex_valid", 32'(id_ex_valid), 32'(e.idex_v));
        check_eq("id_ex_memRead", 32'(id_ex_memRead), 32'(e.idex_mr));
        check_eq("id_ex_regWrite", 32'(id_ex_regWrite), 32'(e.idex_rw));
        check_eq("id_ex_rd", 32'(id_ex_rd_idx), 32'(e.idex_rd));
        check_eq("id_ex_rs1", 32'(id_ex_rs1_idx), 32'(e.idex_rs1));
        check_eq("id_ex_rs2", 32'(id_ex_rs2_idx), 32'(e.idex_rs2));
        check_eq("ex_mem_regWrite", 32'(ex_mem_regWrite), 32'(e.exm_rw));
        check_eq("ex_mem_rd", 32'(ex_mem_rd_idx), 32'(e.exm_rd));
        check_eq("mem_wb_regWrite", 32'(mem_wb_regWrite), 32'(e.mwb_rw));
        check_eq("mem_wb_rd", 32'(mem_wb_rd_idx), 32'(e.mwb_rd));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        check_eq("flush_cnt", 32'(flush_cnt), 32'(e.fc));
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] tgt,
                        input logic [31:0] ins, input logic mr, input logic rw);
        rst = r; stall = s; flush = f; branch_target = tgt;
        if_instr = ins; id_memRead = mr; id_regWrite = rw;
        model_step(r, s, f, tgt, ins, mr, rw);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        m = '{default: '0};
        rst = 1; stall = 0; flush = 0; branch_target = 0; if_instr = 0; id_memRead = 0; id_regWrite = 0;

        step(1, 0, 0, 0, 32'h0, 0, 0);
        step(1, 1, 1, 32'h40, 32'h0, 0, 0);

        // Free-running fetch from reset PC
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, mk(5'(i + 8), 5'(i + 1), 5'(i + 2)), 0, 1);
        end

        // Load x3 then dependent add, one-cycle load-use stall
        step(0, 0, 0, 0, 32'h0000_A183, 0, 1);
        step(0, 0, 0, 0, 32'h0051_8233, 1, 1);
        step(0, 1, 0, 0, 32'h0051_8233, 0, 1);
        step(0, 0, 0, 0, 32'h0051_8233, 0, 1);
        step(0, 0, 0, 0, mk(5'd9, 5'd4, 5'd4), 0, 1);

        // Branch flush, then combined stall+flush
        step(0, 0, 1, 32'h0000_0100, mk(5'd10, 5'd1, 5'd1), 1, 1);
        step(0, 0, 0, 0, mk(5'd11, 5'd2, 5'd2), 0, 1);
        step(0, 1, 1, 32'h0000_0200, mk(5'd12, 5'd3, 5'd3), 1, 1);

        // rd=0 write suppression, rd=7 forwarding path
        step(0, 0, 0, 0, mk(5'd0, 5'd1, 5'd2), 0, 1);
        step(0, 0, 0, 0, mk(5'd7, 5'd3, 5'd4), 0, 1);
        step(0, 0, 0, 0, mk(5'd13, 5'd5, 5'd6), 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, mk(5'd14, 5'd0, 5'd0), 0, 1);
        end

        // PC wrap at top of address space
        step(0, 0, 1, 32'hFFFF_FFFC, mk(5'd15, 5'd1, 5'd1), 0, 0);
        step(0, 0, 0, 0, mk(5'd16, 5'd2, 5'd2), 0, 1);
        step(0, 0, 0, 0, mk(5'd17, 5'd3, 5'd3), 0, 1);

        // Long stall to saturate counter, then reset while stalling
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            step(0, 1, 0, 0, mk(5'd18, 5'd4, 5'd4), 1, 1);
        end
        step(1, 1, 1, 32'h300, mk(5'd19, 5'd5, 5'd5), 1, 1);
        step(0, 0, 0, 0, mk(5'd20, 5'd6, 5'd6), 0, 1);
        step(0, 0, 0, 0, mk(5'd21, 5'd7, 5'd7), 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
